trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//   Trap sequencer and interrupt arbiter in front of the machine-mode CSR file.
//   Round-robin arbitrates NUM_IRQ level interrupt lines, prioritises ecall over them,
//   and freezes fetch while the pipeline drains. Issues a one-cycle trap commit
//   (cause, epc) to the CSR file, redirects the PC to the handler, and sequences mret.
// PARAMETERS
//   NUM_IRQ       2             number of interrupt request lines (1..8)
//   DRAIN_CYCLES  2             fetch-stall cycles before trap commit (>=1)
//   MTVEC_BASE    32'h0000_0000 handler base address
//   VECTORED      0             1: irq target = MTVEC_BASE + 4*cause_code; ecall always BASE
// PORTS
//   clk             in   1        clock
//   reset_n         in   1        synchronous, active-low reset
//   irq             in   NUM_IRQ  level interrupt requests
//   irq_en          in   NUM_IRQ  per-line enable mask
//   mstatus_mie     in   1        global interrupt enable from CSR file
//   ecall_op        in   1        ecall decoded this cycle (1-cycle pulse)
//   mret_op         in   1        mret decoded this cycle (1-cycle pulse)
//   pc              in   32       PC of instruction currently in decode
//   mepc_in         in   32       current mepc from CSR file
//   stop_fetch      out  1        fetch/decode freeze
//   trap_take       out  1        1-cycle pulse: CSR file latches trap_cause/trap_epc
//   trap_cause      out  32       mcause value; bit31=1 for interrupts
//   trap_epc        out  32       PC captured at trap detection
//   pc_redirect_vld out  1        1-cycle pulse: fetch loads pc_redirect
//   pc_redirect     out  32       redirect target
//   irq_ack         out  NUM_IRQ  one-hot 1-cycle grant acknowledge
//   mret_done       out  1        1-cycle pulse on return redirect
//   nested_err      out  1        sticky: ecall seen while in handler
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE; all outputs 0; rr_ptr=0; drain counter=0.
//   - Reset mid-operation aborts the sequence: IDLE and reset values on the next edge.
//   - pend = irq & irq_en & {NUM_IRQ{mstatus_mie}}.
//   - IDLE: stop_fetch=0.
//     - ecall_op=1: latch trap_epc=pc, trap_cause=32'd11, go DRAIN.
//     - Else if |pend: grant the first set bit at or after rr_ptr (wrapping).
//       Latch trap_epc=pc, trap_cause={1'b1,31'd16+idx}, grant=idx, go DRAIN.
//     - Simultaneous ecall and irq: ecall wins; the irq stays pending (level).
//     - mret_op in IDLE is ignored.
//   - DRAIN: stop_fetch=1; counter loads DRAIN_CYCLES-1 on entry and decrements; at 0 go TRAP.
//     - The trap is committed: irq deassertion or mie clear during DRAIN does not cancel it.
//   - TRAP (1 cycle): trap_take=1, pc_redirect_vld=1, stop_fetch=1.
//     - pc_redirect = MTVEC_BASE, or MTVEC_BASE+4*(16+idx) when VECTORED and cause is an irq.
//     - For an irq: irq_ack[idx]=1 and rr_ptr <= (idx+1) mod NUM_IRQ. Ecall leaves rr_ptr unchanged.
//     - Next state HANDLER.
//   - HANDLER: stop_fetch=0; irq ignored (no nesting).
//     - ecall_op sets nested_err (cleared only by reset).
//     - mret_op goes to RETURN.
//   - RETURN (1 cycle): stop_fetch=1, pc_redirect_vld=1, pc_redirect=mepc_in (sampled here), mret_done=1; go IDLE.
//   - Latency: detection edge to trap_take = DRAIN_CYCLES+1 cycles; mret_op to redirect = 1 cycle.
//   - Pulse outputs (trap_take, pc_redirect_vld, irq_ack, mret_done) are high for exactly one cycle.
// TESTING
//   - irq=2'b01, irq_en=2'b11, mie=1, pc=0x100, DRAIN_CYCLES=2 -> stop_fetch 3 cycles;
//     trap_take at cycle 3 with cause 0x80000010, epc 0x100; irq_ack=01; redirect 0x0.
//   - irq=2'b11 held through two trap/mret rounds -> first grant idx0 (ack 01), second idx1 (ack 10).
//   - ecall_op and irq[0] in the same cycle, pc=0x200 -> cause 11, epc 0x200, irq_ack=0;
//     after mret, irq0 is taken next.
//   - In HANDLER: mret_op with mepc_in=0x204 -> next cycle pc_redirect_vld=1,
//     pc_redirect=0x204, mret_done=1; then IDLE.
//   - mie=0 with irq=11 -> no trap. In HANDLER, ecall_op -> nested_err=1, no trap.
//     irq dropped during DRAIN -> trap still taken.
//   - reset_n=0 asserted in DRAIN -> next cycle all outputs 0, state IDLE; VECTORED=1, irq1 -> redirect MTVEC_BASE+0x44.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the trap sequencer and its neighbours (interrupt sources,
// decode stage, CSR file and fetch).
interface trap_ctrl_if #(
    parameter int unsigned NUM_IRQ = 2
);
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_en;
    logic               mstatus_mie;
    logic               ecall_op;
    logic               mret_op;
    logic [31:0]        pc;
    logic [31:0]        mepc_in;

    logic               stop_fetch;
    logic               trap_take;
    logic [31:0]        trap_cause;
    logic [31:0]        trap_epc;
    logic               pc_redirect_vld;
    logic [31:0]        pc_redirect;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               mret_done;
    logic               nested_err;

    // Sequencer side
    modport slave (
        input  irq, irq_en, mstatus_mie, ecall_op, mret_op, pc, mepc_in,
        output stop_fetch, trap_take, trap_cause, trap_epc, pc_redirect_vld,
               pc_redirect, irq_ack, mret_done, nested_err
    );

    // Pipeline / CSR side
    modport master (
        output irq, irq_en, mstatus_mie, ecall_op, mret_op, pc, mepc_in,
        input  stop_fetch, trap_take, trap_cause, trap_epc, pc_redirect_vld,
               pc_redirect, irq_ack, mret_done, nested_err
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer and round-robin interrupt arbiter: freezes fetch while the pipeline
// drains, commits (cause, epc) to the CSR file, redirects to the handler, and sequences mret.
module trap_ctrl #(
    parameter int unsigned NUM_IRQ      = 2,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] MTVEC_BASE   = 32'h0000_0000,
    parameter bit          VECTORED     = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    trap_ctrl_if.slave   bus
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        TRAP    = 3'd2,
        HANDLER = 3'd3,
        RETURN  = 3'd4
    } state_t;

    // First requesting line at or after ptr, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_IRQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            j = (32'(ptr) + k) % NUM_IRQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
        return pick;
    endfunction

    function automatic logic [31:0] irq_cause(input logic [IDX_W-1:0] idx);
        return {1'b1, 31'(32'd16 + 32'(idx))};
    endfunction

    function automatic logic [31:0] trap_target(input logic is_irq, input logic [IDX_W-1:0] idx);
        if (VECTORED && is_irq)
            return MTVEC_BASE + ((32'd16 + 32'(idx)) << 2);
        return MTVEC_BASE;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        if (32'(idx) >= NUM_IRQ - 1)
            return '0;
        return idx + 1'b1;
    endfunction

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nx;
    logic [IDX_W-1:0]     grant_idx, grant_idx_nx;
    logic                 is_irq, is_irq_nx;
    logic [NUM_IRQ-1:0]   pend;

    logic                 stop_fetch, stop_fetch_nx;
    logic                 trap_take, trap_take_nx;
    logic [31:0]          trap_cause, trap_cause_nx;
    logic [31:0]          trap_epc, trap_epc_nx;
    logic                 redir_vld, redir_vld_nx;
    logic [31:0]          redir, redir_nx;
    logic [NUM_IRQ-1:0]   irq_ack, irq_ack_nx;
    logic                 mret_done, mret_done_nx;
    logic                 nested_err, nested_err_nx;

    assign pend = bus.irq & bus.irq_en & {NUM_IRQ{bus.mstatus_mie}};

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Outputs are registered from the next-state decode, so they track the state entered.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        rr_ptr_nx     = rr_ptr;
        grant_idx_nx  = grant_idx;
        is_irq_nx     = is_irq;
        trap_cause_nx = trap_cause;
        trap_epc_nx   = trap_epc;
        redir_nx      = redir;
        nested_err_nx = nested_err;
        stop_fetch_nx = 1'b0;
        trap_take_nx  = 1'b0;
        redir_vld_nx  = 1'b0;
        irq_ack_nx    = '0;
        mret_done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.ecall_op) begin
                    trap_epc_nx   = bus.pc;
                    trap_cause_nx = 32'd11;
                    is_irq_nx     = 1'b0;
                    cnt_nx        = CNT_LOAD;
                    stop_fetch_nx = 1'b1;
                    state_nx      = DRAIN;
                end else if (|pend) begin
                    grant_idx_nx  = rr_pick(pend, rr_ptr);
                    trap_epc_nx   = bus.pc;
                    trap_cause_nx = irq_cause(grant_idx_nx);
                    is_irq_nx     = 1'b1;
                    cnt_nx        = CNT_LOAD;
                    stop_fetch_nx = 1'b1;
                    state_nx      = DRAIN;
                end
            end
            DRAIN: begin
                stop_fetch_nx = 1'b1;
                if (cnt == '0) begin
                    trap_take_nx = 1'b1;
                    redir_vld_nx = 1'b1;
                    redir_nx     = trap_target(is_irq, grant_idx);
                    if (is_irq) begin
                        irq_ack_nx = NUM_IRQ'(1) << grant_idx;
                        rr_ptr_nx  = ptr_after(grant_idx);
                    end
                    state_nx = TRAP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            TRAP: begin
                state_nx = HANDLER;
            end
            HANDLER: begin
                // No nesting: interrupts are ignored, a second ecall is only flagged.
                if (bus.ecall_op)
                    nested_err_nx = 1'b1;
                if (bus.mret_op) begin
                    stop_fetch_nx = 1'b1;
                    redir_vld_nx  = 1'b1;
                    redir_nx      = bus.mepc_in;
                    mret_done_nx  = 1'b1;
                    state_nx      = RETURN;
                end
            end
            RETURN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            is_irq     <= 1'b0;
            stop_fetch <= 1'b0;
            trap_take  <= 1'b0;
            trap_cause <= '0;
            trap_epc   <= '0;
            redir_vld  <= 1'b0;
            redir      <= '0;
            irq_ack    <= '0;
            mret_done  <= 1'b0;
            nested_err <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            rr_ptr     <= rr_ptr_nx;
            grant_idx  <= grant_idx_nx;
            is_irq     <= is_irq_nx;
            stop_fetch <= stop_fetch_nx;
            trap_take  <= trap_take_nx;
            trap_cause <= trap_cause_nx;
            trap_epc   <= trap_epc_nx;
            redir_vld  <= redir_vld_nx;
            redir      <= redir_nx;
            irq_ack    <= irq_ack_nx;
            mret_done  <= mret_done_nx;
            nested_err <= nested_err_nx;
        end
    end

    assign bus.stop_fetch      = stop_fetch;
    assign bus.trap_take       = trap_take;
    assign bus.trap_cause      = trap_cause;
    assign bus.trap_epc        = trap_epc;
    assign bus.pc_redirect_vld = redir_vld;
    assign bus.pc_redirect     = redir;
    assign bus.irq_ack         = irq_ack;
    assign bus.mret_done       = mret_done;
    assign bus.nested_err      = nested_err;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: irq/ecall trap sequences, round-robin, mret, reset abort, vectoring.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    trap_ctrl_if #(.NUM_IRQ(2)) a_if ();
    trap_ctrl_if #(.NUM_IRQ(2)) b_if ();

    trap_ctrl #(
        .NUM_IRQ(2), .DRAIN_CYCLES(2), .MTVEC_BASE(32'h0000_0000), .VECTORED(1'b0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if)
    );

    trap_ctrl #(
        .NUM_IRQ(2), .DRAIN_CYCLES(2), .MTVEC_BASE(32'h0000_1000), .VECTORED(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        a_if.irq         = '0;  a_if.irq_en = '0;  a_if.mstatus_mie = 1'b0;
        a_if.ecall_op    = 1'b0; a_if.mret_op = 1'b0;
        a_if.pc          = '0;  a_if.mepc_in = '0;
        b_if.irq         = '0;  b_if.irq_en = '0;  b_if.mstatus_mie = 1'b0;
        b_if.ecall_op    = 1'b0; b_if.mret_op = 1'b0;
        b_if.pc          = '0;  b_if.mepc_in = '0;
        step(2);

        chk("rst_stop",   32'(a_if.stop_fetch), 32'd0);
        chk("rst_take",   32'(a_if.trap_take), 32'd0);
        chk("rst_cause",  a_if.trap_cause, 32'd0);
        chk("rst_epc",    a_if.trap_epc, 32'd0);
        chk("rst_ack",    32'(a_if.irq_ack), 32'd0);
        chk("rst_vld",    32'(a_if.pc_redirect_vld), 32'd0);
        chk("rst_nested", 32'(a_if.nested_err), 32'd0);

        reset_n = 1'b1;
        step(1);

        // irq0 taken; line dropped during DRAIN, trap still committed
        a_if.irq = 2'b01; a_if.irq_en = 2'b11; a_if.mstatus_mie = 1'b1; a_if.pc = 32'h100;
        step(1);
        chk("t1_stop_c1", 32'(a_if.stop_fetch), 32'd1);
        chk("t1_take_c1", 32'(a_if.trap_take), 32'd0);
        chk("t1_epc_c1",  a_if.trap_epc, 32'h100);
        a_if.irq = 2'b00;
        step(1);
        chk("t1_stop_c2", 32'(a_if.stop_fetch), 32'd1);
        chk("t1_take_c2", 32'(a_if.trap_take), 32'd0);
        step(1);
        chk("t1_take",  32'(a_if.trap_take), 32'd1);
        chk("t1_stop",  32'(a_if.stop_fetch), 32'd1);
        chk("t1_cause", a_if.trap_cause, 32'h8000_0010);
        chk("t1_epc",   a_if.trap_epc, 32'h100);
        chk("t1_ack",   32'(a_if.irq_ack), 32'b01);
        chk("t1_vld",   32'(a_if.pc_redirect_vld), 32'd1);
        chk("t1_redir", a_if.pc_redirect, 32'h0);
        step(1);
        chk("t1_h_take", 32'(a_if.trap_take), 32'd0);
        chk("t1_h_ack",  32'(a_if.irq_ack), 32'd0);
        chk("t1_h_vld",  32'(a_if.pc_redirect_vld), 32'd0);
        chk("t1_h_stop", 32'(a_if.stop_fetch), 32'd0);

        // mret from handler
        a_if.mepc_in = 32'h204; a_if.mret_op = 1'b1;
        step(1);
        a_if.mret_op = 1'b0;
        chk("mret_vld",   32'(a_if.pc_redirect_vld), 32'd1);
        chk("mret_redir", a_if.pc_redirect, 32'h204);
        chk("mret_done",  32'(a_if.mret_done), 32'd1);
        chk("mret_stop",  32'(a_if.stop_fetch), 32'd1);
        step(1);
        chk("mret_idle_done", 32'(a_if.mret_done), 32'd0);
        chk("mret_idle_vld",  32'(a_if.pc_redirect_vld), 32'd0);
        chk("mret_idle_stop", 32'(a_if.stop_fetch), 32'd0);

        // reset in DRAIN aborts the sequence and clears rr_ptr
        a_if.irq = 2'b11;
        step(1);
        chk("rd_stop_pre", 32'(a_if.stop_fetch), 32'd1);
        reset_n = 1'b0;
        step(1);
        chk("rd_stop",  32'(a_if.stop_fetch), 32'd0);
        chk("rd_cause", a_if.trap_cause, 32'd0);
        chk("rd_epc",   a_if.trap_epc, 32'd0);
        chk("rd_take",  32'(a_if.trap_take), 32'd0);
        reset_n = 1'b1;

        // irq=11 held: round-robin idx0 then idx1
        a_if.pc = 32'h300;
        step(1);
        chk("rr1_stop", 32'(a_if.stop_fetch), 32'd1);
        step(2);
        chk("rr1_take",  32'(a_if.trap_take), 32'd1);
        chk("rr1_ack",   32'(a_if.irq_ack), 32'b01);
        chk("rr1_cause", a_if.trap_cause, 32'h8000_0010);
        chk("rr1_epc",   a_if.trap_epc, 32'h300);
        step(2);
        chk("rr1_hnd_stop", 32'(a_if.stop_fetch), 32'd0);
        chk("rr1_hnd_take", 32'(a_if.trap_take), 32'd0);
        a_if.mepc_in = 32'h300; a_if.mret_op = 1'b1;
        step(1);
        a_if.mret_op = 1'b0;
        chk("rr1_mret_done", 32'(a_if.mret_done), 32'd1);
        step(1);
        chk("rr1_idle_stop", 32'(a_if.stop_fetch), 32'd0);
        step(1);
        chk("rr2_stop", 32'(a_if.stop_fetch), 32'd1);
        step(2);
        chk("rr2_take",  32'(a_if.trap_take), 32'd1);
        chk("rr2_ack",   32'(a_if.irq_ack), 32'b10);
        chk("rr2_cause", a_if.trap_cause, 32'h8000_0011);
        step(1);

        // ecall inside the handler: sticky error, no trap
        a_if.ecall_op = 1'b1;
        step(1);
        a_if.ecall_op = 1'b0;
        chk("nest_err",  32'(a_if.nested_err), 32'd1);
        chk("nest_stop", 32'(a_if.stop_fetch), 32'd0);
        step(1);
        chk("nest_take", 32'(a_if.trap_take), 32'd0);
        a_if.irq = 2'b00; a_if.mepc_in = 32'h304; a_if.mret_op = 1'b1;
        step(1);
        a_if.mret_op = 1'b0;
        step(1);

        // ecall and irq0 together: ecall wins, irq0 follows after mret
        a_if.irq = 2'b01; a_if.ecall_op = 1'b1; a_if.pc = 32'h200;
        step(1);
        a_if.ecall_op = 1'b0;
        chk("ec_stop", 32'(a_if.stop_fetch), 32'd1);
        step(2);
        chk("ec_take",  32'(a_if.trap_take), 32'd1);
        chk("ec_cause", a_if.trap_cause, 32'd11);
        chk("ec_epc",   a_if.trap_epc, 32'h200);
        chk("ec_ack",   32'(a_if.irq_ack), 32'd0);
        chk("ec_redir", a_if.pc_redirect, 32'h0);
        step(1);
        a_if.mepc_in = 32'h204; a_if.mret_op = 1'b1;
        step(1);
        a_if.mret_op = 1'b0;
        step(1);
        step(3);
        chk("ec_irq_take",  32'(a_if.trap_take), 32'd1);
        chk("ec_irq_cause", a_if.trap_cause, 32'h8000_0010);
        chk("ec_irq_ack",   32'(a_if.irq_ack), 32'b01);
        step(1);
        a_if.irq = 2'b00; a_if.mret_op = 1'b1;
        step(1);
        a_if.mret_op = 1'b0;
        step(1);

        // global enable off: no trap; mret in IDLE ignored
        a_if.mstatus_mie = 1'b0; a_if.irq = 2'b11;
        step(4);
        chk("mie0_stop", 32'(a_if.stop_fetch), 32'd0);
        chk("mie0_take", 32'(a_if.trap_take), 32'd0);
        a_if.mret_op = 1'b1;
        step(1);
        a_if.mret_op = 1'b0;
        chk("idle_mret_done", 32'(a_if.mret_done), 32'd0);
        chk("idle_mret_vld",  32'(a_if.pc_redirect_vld), 32'd0);
        chk("nest_sticky",    32'(a_if.nested_err), 32'd1);

        // vectored instance: irq1 -> base + 4*17
        b_if.irq = 2'b10; b_if.irq_en = 2'b11; b_if.mstatus_mie = 1'b1; b_if.pc = 32'h400;
        step(3);
        chk("vec_take",  32'(b_if.trap_take), 32'd1);
        chk("vec_redir", b_if.pc_redirect, 32'h0000_1044);
        chk("vec_ack",   32'(b_if.irq_ack), 32'b10);
        chk("vec_cause", b_if.trap_cause, 32'h8000_0011);
        step(1);
        chk("vec_take_pulse", 32'(b_if.trap_take), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
